// File: rtl/clos_cm_alloc_if.sv
// Bundle of request/grant/release signals between the input modules and
// the central-module path allocator of the SDM-Clos router switch.
// Optional occupancy outputs appear when CLOS_ALLOC_OCC_EN is defined.
//
// Handshake: req[k] is a level held with a stable req_dst[k] until the
// allocator answers with a one-cycle gnt[k] or nack[k] pulse, registered at
// the edge that sampled the request. A req[k] still high during its own
// gnt/nack cycle is ignored for that cycle and counts as a new request
// afterwards. rel[k] is a single-cycle pulse and needs no answer other than
// rel_err[k] when it names a link that IM k does not hold.
interface clos_cm_alloc_if #(
    parameter int MN = 2,
    parameter int CW = (MN > 1) ? $clog2(MN) : 1,
    parameter int OW = $clog2(MN + 1)
);
    logic [4:0]             req;
    logic [4:0][2:0]        req_dst;
    logic [4:0]             gnt;
    logic [CW-1:0]          gnt_cm;
    logic [4:0]             nack;
    logic [4:0]             rel;
    logic [4:0][CW-1:0]     rel_cm;
    logic [4:0]             rel_err;
    logic [MN-1:0][4:0]     cm_vld;
    logic [MN-1:0][4:0][2:0] cm_src;
`ifdef CLOS_ALLOC_OCC_EN
    logic [4:0][OW-1:0]     occ;
    logic [4:0]             full;
`endif

    modport master (
        output req, req_dst, rel, rel_cm,
`ifdef CLOS_ALLOC_OCC_EN
        input  occ, full,
`endif
        input  gnt, gnt_cm, nack, rel_err, cm_vld, cm_src
    );

    modport slave (
        input  req, req_dst, rel, rel_cm,
`ifdef CLOS_ALLOC_OCC_EN
        output occ, full,
`endif
        output gnt, gnt_cm, nack, rel_err, cm_vld, cm_src
    );
endinterface

// File: rtl/clos_cm_alloc.sv
// Central-module path allocator for the 5-port SDM-Clos router switch.
// Each cycle at most one input module is granted a CM whose IM->CM and
// CM->OM links are both free; releases free links in parallel.
// Optional feature macro: CLOS_ALLOC_OCC_EN (per-IM link occupancy and
// full flags; full IMs are excluded from arbitration).
module clos_cm_alloc #(
    parameter int MN = 2,
    parameter int CW = (MN > 1) ? $clog2(MN) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    clos_cm_alloc_if.slave  bus
);
    localparam int OW = $clog2(MN + 1);

    // Link state: im_busy[k][m] = IM k -> CM m in use; om_busy[o][m] = CM m -> OM o in use.
    logic [MN-1:0]            im_busy [5];
    logic [MN-1:0]            om_busy [5];
    logic [2:0]               path_dst [5][MN];
    logic [MN-1:0][4:0][2:0]  src_q;
    logic [2:0]               rr_ptr;
    logic [4:0]               gnt_q, nack_q, rel_err_q;
    logic [CW-1:0]            gnt_cm_q;

    logic [MN-1:0]            im_n [5];
    logic [MN-1:0]            om_n [5];
    logic [2:0]               dst_n [5][MN];
    logic [MN-1:0][4:0][2:0]  src_n;
    logic [2:0]               rr_n;
    logic [4:0]               gnt_n, nack_n, rel_err_n, legal, elig, full_w;
    logic [CW-1:0]            gnt_cm_n;
    logic                     found;
    int                       win_k, win_m, k, c, o, d;

`ifdef CLOS_ALLOC_OCC_EN
    logic [OW-1:0] occ_c;
    // Per-IM occupancy follows the registered link state.
    always_comb begin
        bus.occ = '0;
        full_w  = '0;
        occ_c   = '0;
        for (int i = 0; i < 5; i++) begin
            occ_c = '0;
            for (int m = 0; m < MN; m++) occ_c = occ_c + OW'(im_busy[i][m]);
            bus.occ[i] = occ_c;
            full_w[i]  = (occ_c == OW'(MN));
        end
        bus.full = full_w;
    end
`else
    assign full_w = '0;
`endif

    // Legality, round-robin arbitration on pre-release state, then release and grant updates.
    always_comb begin
        im_n = im_busy; om_n = om_busy; dst_n = path_dst; src_n = src_q; rr_n = rr_ptr;
        gnt_n = '0; gnt_cm_n = '0; nack_n = '0; rel_err_n = '0;
        legal = '0; elig = '0; found = 1'b0;
        win_k = 0; win_m = 0; k = 0; c = 0; o = 0; d = 0;

        for (int i = 0; i < 5; i++) begin
            legal[i]  = (bus.req_dst[i] <= 3'd4) && (int'(bus.req_dst[i]) != i);
            // The answered request is ignored for one cycle so a held level is not re-answered.
            nack_n[i] = bus.req[i] && !legal[i] && !gnt_q[i] && !nack_q[i];
            elig[i]   = bus.req[i] && legal[i] && !gnt_q[i] && !full_w[i];
        end

        for (int i = 0; i < 5; i++) begin
            k = int'(rr_ptr) + i;
            if (k > 4) k = k - 5;
            if (!found && elig[k]) begin
                d = int'(bus.req_dst[k]);
                for (int m = 0; m < MN; m++) begin
                    if (!found && !im_busy[k][m] && !om_busy[d][m]) begin
                        found = 1'b1;
                        win_k = k;
                        win_m = m;
                    end
                end
            end
        end

        for (int i = 0; i < 5; i++) begin
            if (bus.rel[i]) begin
                c = int'(bus.rel_cm[i]);
                if (c < MN && im_busy[i][c]) begin
                    o = int'(path_dst[i][c]);
                    im_n[i][c]  = 1'b0;
                    om_n[o][c]  = 1'b0;
                    dst_n[i][c] = 3'd0;
                    src_n[c][o] = 3'd0;
                end else begin
                    rel_err_n[i] = 1'b1;
                end
            end
        end

        // A grant never lands on a link released this cycle, so applying it last is safe.
        if (found) begin
            d = int'(bus.req_dst[win_k]);
            im_n[win_k][win_m]  = 1'b1;
            om_n[d][win_m]      = 1'b1;
            dst_n[win_k][win_m] = 3'(d);
            src_n[win_m][d]     = 3'(win_k);
            gnt_n[win_k]        = 1'b1;
            gnt_cm_n            = CW'(win_m);
            rr_n                = (win_k == 4) ? 3'd0 : 3'(win_k + 1);
        end
    end

    // State register; reset drops every path immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                im_busy[i] <= '0;
                om_busy[i] <= '0;
                for (int m = 0; m < MN; m++) path_dst[i][m] <= 3'd0;
            end
            src_q     <= '0;
            rr_ptr    <= 3'd0;
            gnt_q     <= '0;
            gnt_cm_q  <= '0;
            nack_q    <= '0;
            rel_err_q <= '0;
        end else begin
            im_busy   <= im_n;
            om_busy   <= om_n;
            path_dst  <= dst_n;
            src_q     <= src_n;
            rr_ptr    <= rr_n;
            gnt_q     <= gnt_n;
            gnt_cm_q  <= gnt_cm_n;
            nack_q    <= nack_n;
            rel_err_q <= rel_err_n;
        end
    end

    // CM m drives OM o exactly when the CM->OM link is held.
    always_comb begin
        bus.cm_vld = '0;
        for (int m = 0; m < MN; m++)
            for (int i = 0; i < 5; i++) bus.cm_vld[m][i] = om_busy[i][m];
    end

    assign bus.cm_src  = src_q;
    assign bus.gnt     = gnt_q;
    assign bus.gnt_cm  = gnt_cm_q;
    assign bus.nack    = nack_q;
    assign bus.rel_err = rel_err_q;

`ifndef SYNTHESIS
    function automatic int owners(int m, int oi);
        int n = 0;
        for (int i = 0; i < 5; i++)
            if (im_busy[i][m] && int'(path_dst[i][m]) == oi) n++;
        return n;
    endfunction

    // Each driven (CM, OM) pair has exactly one owning IM, and each held OM link has one driver.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int m = 0; m < MN; m++)
                for (int oi = 0; oi < 5; oi++)
                    assert (owners(m, oi) == int'(om_busy[oi][m]));
        end
    end
`endif
endmodule
